mult_div_unit: RTL and testbench
================================

# mult_div_unit

Execute-stage multiply/divide unit. It sits beside the ALU in stage E, consumes the forwarded operands E_GRF_RD1_f / E_GRF_RD2_f, and holds the architectural HI/LO registers. It models fixed multi-cycle latency with a busy counter. The HCU uses start/busy to stall any multiply/divide-class instruction in D. mfhi/mflo data leaves through the E-stage result path.

## Interface
Parameters:
- MULT_CYCLES, 5, busy duration of mult/multu in cycles (≥1)
- DIV_CYCLES, 10, busy duration of div/divu in cycles (≥1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high; clears all state
- start  input  1  E-stage instruction is mult/multu/div/divu; one-cycle pulse
- md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- A  input  32  rs operand (forwarded)
- B  input  32  rt operand (forwarded)
- read_sel  input  1  0 LO, 1 HI
- busy  output  1  operation in flight
- HI  output  32  architectural HI
- LO  output  32  architectural LO
- read_data  output  32  combinational: read_sel ? HI : LO

## Operation
- States: IDLE (busy=0), RUN (busy=1, counter>0).
- IDLE + start with md_op∈{1..4}:
  - latch the result into internal hi_tmp/lo_tmp;
  - load the counter with MULT_CYCLES or DIV_CYCLES;
  - go to RUN.
- RUN: the counter decrements each cycle. On the edge where the counter goes 1→0:
  - copy hi_tmp/lo_tmp into HI/LO;
  - return to IDLE.
- mult: {HI,LO} = $signed(A)*$signed(B), full 64 bits.
- multu: the same, unsigned.
- div: LO = signed quotient truncated toward zero; HI = remainder, with the sign of the dividend.
- divu: unsigned quotient and remainder.
- Divide by zero (B==0) for div/divu:
  - the unit still goes busy for DIV_CYCLES;
  - HI/LO are left unchanged at completion.
- mthi/mtlo (md_op 5/6, start=0) in IDLE: HI or LO ← A at the clock edge. No busy.
- start or mthi/mtlo while busy=1 is a protocol violation (the HCU prevents it). The unit must ignore it: no state change, and the counter continues.
- start=1 with md_op∉{1..4}: ignored.
- HI/LO change only at completion or on mthi/mtlo. They are never observed mid-operation.

## Timing
- Reset values: busy=0, HI=0, LO=0, counter=0, hi_tmp=lo_tmp=0. read_data then follows HI/LO.
- Reset asserted mid-operation: the operation is aborted, and on the next edge all state is cleared as above.
- Start sampled at edge t (start=1 during the cycle before t):
  - busy=1 in cycles t..t+N-1, where N=MULT_CYCLES or DIV_CYCLES;
  - HI/LO take the new value at edge t+N;
  - busy=0 from t+N onward.
- Back-to-back: a new start may be accepted in the same cycle busy first reads 0.
- read_data is zero-latency combinational. An mfhi in E in the cycle after completion sees the new value.
- HCU stall contract (outside this block): stall D when the D instruction is md-class and (start | busy).

## Test plan
- Reset, then mthi A=0x12345678 → HI=0x12345678 next edge, LO=0, busy=0 throughout.
- mult A=0xFFFFFFFE (−2), B=3 → busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- div A=0xFFFFFFF9 (−7), B=2 → busy 10 cycles; LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). divu A=7, B=2 → LO=3, HI=1.
- div with B=0, starting from HI=0xAA, LO=0xBB → busy 10 cycles; HI/LO remain 0xAA/0xBB.
- mult started, then start=1 div and mtlo A=5 issued on cycle 2 of busy → both ignored; mult result lands at cycle 5; busy drops on schedule.
- Reset asserted on cycle 3 of a div → busy=0, HI=LO=0 after that edge. A subsequent mult B=1 completes normally.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: E-stage multiply/divide unit holding architectural HI/LO with fixed multi-cycle busy latency
// Ports: clk/reset (sync, active-high); start + md_op + A/B issue an operation;
// read_sel picks HI(1)/LO(0) onto read_data; busy flags an operation in flight.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        read_sel,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] read_data
);
  localparam int CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [31:0] hi_tmp, lo_tmp;
  logic skip, accept, done, move_ok, is_div, sdiv;
  logic [31:0] mag_a, mag_b, q_u, r_u, q, r;
  logic [63:0] prod, res;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb state_nx = (state == IDLE) ? (accept ? RUN : IDLE) : (done ? IDLE : RUN);
  always_comb begin
    busy    = state == RUN;
    accept  = state == IDLE && start && md_op >= 3'd1 && md_op <= 3'd4;
    done    = state == RUN && cnt == CW'(1);
    move_ok = state == IDLE && !start;
  end
  // Division runs on magnitudes so that -2^31 / -1 wraps cleanly instead of overflowing.
  always_comb begin
    is_div = md_op == 3'd3 || md_op == 3'd4;
    sdiv   = md_op == 3'd3;
    mag_a  = (sdiv && A[31]) ? -A : A;
    mag_b  = (sdiv && B[31]) ? -B : B;
    q_u    = mag_a / mag_b;
    r_u    = mag_a % mag_b;
    q      = (sdiv && (A[31] ^ B[31])) ? -q_u : q_u;
    r      = (sdiv && A[31]) ? -r_u : r_u;
    prod   = (md_op == 3'd1) ? {{32{A[31]}}, A} * {{32{B[31]}}, B} : {32'b0, A} * {32'b0, B};
    res    = is_div ? {r, q} : prod;
  end
  // A divide by zero still occupies the unit but must not disturb HI/LO.
  always_ff @(posedge clk)
    if (reset) begin
      cnt    <= '0;
      hi_tmp <= '0;
      lo_tmp <= '0;
      skip   <= 1'b0;
      HI     <= '0;
      LO     <= '0;
    end else begin
      if (accept) begin
        {hi_tmp, lo_tmp} <= res;
        skip <= is_div && B == 32'd0;
        cnt  <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (busy) cnt <= cnt - CW'(1);
      if (done && !skip) begin
        HI <= hi_tmp;
        LO <= lo_tmp;
      end
      if (move_ok && md_op == 3'd5) HI <= A;
      if (move_ok && md_op == 3'd6) LO <= A;
    end
  assign read_data = read_sel ? HI : LO;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: self-checking bench for mult_div_unit (directed table, corner sequences, random vs model)
module tb_mult_div_unit;
  logic clk = 1'b0, reset, start, read_sel, busy;
  logic [2:0] md_op;
  logic [31:0] A, B, HI, LO, read_data, mhi, mlo;
  int n_cmp = 0, n_bad = 0, cyc;
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    int          cyc;
  } vec_t;
  vec_t vt [13];
  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .A(A), .B(B),
    .read_sel(read_sel), .busy(busy), .HI(HI), .LO(LO), .read_data(read_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic check_regs(input string nm, input logic [31:0] hi, input logic [31:0] lo);
    chk({nm, " HI"}, 64'(HI), 64'(hi));
    chk({nm, " LO"}, 64'(LO), 64'(lo));
    read_sel = 1'b1;
    #1 chk({nm, " read_data HI"}, 64'(read_data), 64'(hi));
    read_sel = 1'b0;
    #1 chk({nm, " read_data LO"}, 64'(read_data), 64'(lo));
  endtask
  task automatic wait_idle(inout int c);
    while (busy && c < 50) begin
      c++;
      @(negedge clk);
    end
  endtask
  task automatic apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int c);
    start = op >= 3'd1 && op <= 3'd4;
    md_op = op;
    A = a;
    B = b;
    @(negedge clk);
    start = 1'b0;
    md_op = 3'd0;
    c = 0;
    wait_idle(c);
  endtask
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int c);
    int ia, ib;
    longint sa, sb;
    logic [63:0] p;
    ia = a;
    ib = b;
    sa = ia;
    sb = ib;
    c = (op == 3'd1 || op == 3'd2) ? 5 : (op == 3'd3 || op == 3'd4) ? 10 : 0;
    case (op)
      3'd1: begin p = sa * sb; {mhi, mlo} = p; end
      3'd2: begin p = {32'b0, a} * {32'b0, b}; {mhi, mlo} = p; end
      3'd3: if (b != 0) begin p = sa / sb; mlo = p[31:0]; p = sa % sb; mhi = p[31:0]; end
      3'd4: if (b != 0) begin mlo = a / b; mhi = a % b; end
      3'd5: mhi = a;
      3'd6: mlo = a;
      default: ;
    endcase
  endtask
  initial begin
    vt[0]  = '{3'd5, 32'h12345678, 32'h0,        32'h12345678, 32'h0,        0};
    vt[1]  = '{3'd1, 32'hFFFFFFFE, 32'h3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vt[2]  = '{3'd2, 32'hFFFFFFFE, 32'h3,        32'h00000002, 32'hFFFFFFFA, 5};
    vt[3]  = '{3'd3, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vt[4]  = '{3'd4, 32'h7,        32'h2,        32'h1,        32'h3,        10};
    vt[5]  = '{3'd5, 32'hAA,       32'h0,        32'hAA,       32'h3,        0};
    vt[6]  = '{3'd6, 32'hBB,       32'h0,        32'hAA,       32'hBB,       0};
    vt[7]  = '{3'd3, 32'h55,       32'h0,        32'hAA,       32'hBB,       10};
    vt[8]  = '{3'd4, 32'h9,        32'h0,        32'hAA,       32'hBB,       10};
    vt[9]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 10};
    vt[10] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        5};
    vt[11] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vt[12] = '{3'd3, 32'h7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD, 10};
    reset = 1'b1;
    start = 1'b0;
    md_op = 3'd0;
    A = 32'd0;
    B = 32'd0;
    read_sel = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    check_regs("reset", 32'd0, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    foreach (vt[i]) begin
      apply(vt[i].op, vt[i].a, vt[i].b, cyc);
      chk($sformatf("vec%0d busy cycles", i), 64'(cyc), 64'(vt[i].cyc));
      check_regs($sformatf("vec%0d", i), vt[i].hi, vt[i].lo);
    end
    mhi = vt[12].hi;
    mlo = vt[12].lo;
    foreach (vt[i]) if (i < 3) begin
      start = 1'b1;
      md_op = (i == 0) ? 3'd5 : (i == 1) ? 3'd7 : 3'd0;
      A = 32'hDEAD;
      @(negedge clk);
      chk($sformatf("ignored start op%0d busy", md_op), 64'(busy), 64'd0);
    end
    start = 1'b0;
    md_op = 3'd0;
    check_regs("ignored starts", mhi, mlo);
    start = 1'b1;
    md_op = 3'd1;
    A = 32'd3;
    B = 32'd4;
    @(negedge clk);
    cyc = int'(busy);
    md_op = 3'd3;
    A = 32'd100;
    B = 32'd7;
    @(negedge clk);
    cyc += int'(busy);
    start = 1'b0;
    md_op = 3'd6;
    A = 32'd5;
    @(negedge clk);
    cyc += int'(busy);
    md_op = 3'd0;
    @(negedge clk);
    wait_idle(cyc);
    chk("violation busy cycles", 64'(cyc), 64'd5);
    check_regs("violation", 32'd0, 32'd12);
    start = 1'b1;
    md_op = 3'd3;
    A = 32'd100;
    B = 32'd7;
    @(negedge clk);
    start = 1'b0;
    md_op = 3'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midop reset busy", 64'(busy), 64'd0);
    check_regs("midop reset", 32'd0, 32'd0);
    apply(3'd1, 32'h1234, 32'd1, cyc);
    chk("post reset mult cycles", 64'(cyc), 64'd5);
    check_regs("post reset mult", 32'd0, 32'h1234);
    mhi = 32'd0;
    mlo = 32'h1234;
    for (int i = 0; i < 60; i++) begin
      logic [2:0] op;
      logic [31:0] a, b;
      int ecyc;
      op = 3'($urandom_range(1, 6));
      a = (i % 5 == 0) ? 32'h80000000 : $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : (i % 7 == 0) ? 32'hFFFFFFFF : $urandom;
      model(op, a, b, ecyc);
      apply(op, a, b, cyc);
      chk($sformatf("rand%0d op%0d cycles", i, op), 64'(cyc), 64'(ecyc));
      check_regs($sformatf("rand%0d op%0d", i, op), mhi, mlo);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
